// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared constants, response tag type and access-check helper for
//           the two-port memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   localparam logic PORT_CPU         = 1'b0;
   localparam logic PORT_DBG         = 1'b1;
   localparam int   DEF_STARVE_LIMIT = 4;
   localparam int   DEF_AW           = 12;

   // Owner tag captured at grant time and used to route the response one cycle later
   typedef struct packed {
      logic valid;
      logic owner;
      logic load;
      logic err;
   } resp_tag_t;

   // Out-of-range word index, empty store, or a full-word store that is not word aligned
   function automatic logic access_err(input logic [31:0] addr,
                                       input logic        we,
                                       input logic [3:0]  be,
                                       input int          aw);
      logic range_err;
      logic align_err;
      range_err = (addr >> (aw + 2)) != 32'd0;
      align_err = we && ((be == 4'b0000) || ((be == 4'b1111) && (addr[1:0] != 2'b00)));
      return range_err || align_err;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_starve_ctr
// Purpose : Saturating count of consecutive denied cycles for the low-priority
//           port; raises force_win once the limit is reached.
// Rev     : 1.0  initial release
// ============================================================================
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
)(
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic gnt,
   output logic force_win
);

   // +2 keeps the counter at least one bit wide even for a limit of zero
   localparam int CW = $clog2(STARVE_LIMIT + 2);

   logic [CW-1:0] count;

   // Count denied cycles, clear on any grant or dropped request, hold at the limit
   always_ff @(posedge clk) begin
      if (reset || gnt || !req) begin
         count <= '0;
      end else if (count != CW'(STARVE_LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   assign force_win = (count == CW'(STARVE_LIMIT));

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb
// Purpose : Two-port single-memory arbiter. Port 0 has fixed priority, port 1
//           is forced through after STARVE_LIMIT denied cycles. Grants and the
//           memory strobe are combinational; responses come one cycle later.
// Rev     : 1.0  initial release
// ============================================================================
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int AW           = DEF_AW
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [31:0]   p0_addr,
   input  logic [31:0]   p0_wdata,
   input  logic [3:0]    p0_be,
   output logic          p0_gnt,
   output logic          p0_rvalid,
   output logic [31:0]   p0_rdata,
   output logic          p0_err,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [31:0]   p1_addr,
   input  logic [31:0]   p1_wdata,
   input  logic [3:0]    p1_be,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [31:0]   p1_rdata,
   output logic          p1_err,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   output logic [3:0]    m_be,
   input  logic [31:0]   m_rdata
);

   logic        force_win;
   logic        gnt0;
   logic        gnt1;
   logic        any_gnt;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_be;
   logic        sel_err;
   logic        resp_valid;
   logic [31:0] resp_data;
   resp_tag_t   tag;

   mem_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk       (clk),
      .reset     (reset),
      .req       (p1_req),
      .gnt       (gnt1),
      .force_win (force_win)
   );

   // Fixed priority to port 0 unless port 1 has been starved; nothing while in reset
   always_comb begin
      gnt1    = !reset && p1_req && (force_win || !p0_req);
      gnt0    = !reset && p0_req && !gnt1;
      any_gnt = gnt0 || gnt1;
   end

   assign p0_gnt = gnt0;
   assign p1_gnt = gnt1;

   // Select the winning request and drive the memory strobe; errored grants stay off the bus
   always_comb begin
      sel_we    = gnt1 ? p1_we    : p0_we;
      sel_addr  = gnt1 ? p1_addr  : p0_addr;
      sel_wdata = gnt1 ? p1_wdata : p0_wdata;
      sel_be    = gnt1 ? p1_be    : p0_be;
      sel_err   = access_err(sel_addr, sel_we, sel_be, AW);
      m_en      = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_be      = '0;
      if (any_gnt && !sel_err) begin
         m_en    = 1'b1;
         m_we    = sel_we;
         m_addr  = sel_addr[AW+1:2];
         m_wdata = sel_wdata;
         m_be    = sel_be;
      end
   end

   // Remember who was granted and what kind of access it was, for next-cycle routing
   always_ff @(posedge clk) begin
      if (reset) begin
         tag <= '0;
      end else begin
         tag.valid <= any_gnt;
         tag.owner <= gnt1 ? PORT_DBG : PORT_CPU;
         tag.load  <= !sel_we;
         tag.err   <= sel_err;
      end
   end

   // Route the response to its owner; a response pending when reset rises is dropped
   always_comb begin
      resp_valid = tag.valid && !reset;
      resp_data  = (tag.load && !tag.err) ? m_rdata : 32'd0;
      p0_rvalid  = resp_valid && (tag.owner == PORT_CPU);
      p1_rvalid  = resp_valid && (tag.owner == PORT_DBG);
      p0_rdata   = p0_rvalid ? resp_data : 32'd0;
      p1_rdata   = p1_rvalid ? resp_data : 32'd0;
      p0_err     = p0_rvalid && tag.err;
      p1_err     = p1_rvalid && tag.err;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arb
// Purpose : Self-checking bench for mem_arb: per-port request queues drive the
//           DUT, an arbitration/memory reference model predicts grants, bus
//           strobes and responses, and a scoreboard holds pending responses.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arb;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0] p0_addr = '0, p0_wdata = '0;
   logic [3:0]  p0_be = '0;
   logic        p0_gnt, p0_rvalid, p0_err;
   logic [31:0] p0_rdata;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p1_addr = '0, p1_wdata = '0;
   logic [3:0]  p1_be = '0;
   logic        p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p1_rdata;
   logic        m_en, m_we;
   logic [11:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_rdata = '0;

   always #5 clk = ~clk;

   mem_arb #(
      .STARVE_LIMIT (LIMIT),
      .AW           (12)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_be     (p0_be),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p0_err    (p0_err),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_be     (p1_be),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .p1_err    (p1_err),
      .m_en      (m_en),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_be      (m_be),
      .m_rdata   (m_rdata)
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   typedef struct {
      bit          port;
      logic [31:0] data;
      bit          err;
   } exp_t;

   req_t        rq0[$];
   req_t        rq1[$];
   exp_t        sb[$];
   logic [31:0] mem     [0:4095];
   logic [31:0] ref_mem [0:4095];
   int          n_cmp = 0;
   int          n_err = 0;
   int          wait_cnt = 0;
   bit          seen0 = 1'b0;
   bit          seen1 = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit model_err(input logic [31:0] addr, input bit we, input logic [3:0] be);
      logic [1:0] lo;
      lo = addr[1:0];
      return (addr >= 32'h0000_4000) || (we && ((be == 4'h0) || ((be == 4'hF) && (lo != 2'b00))));
   endfunction

   // Memory behind the arbiter: registered read, byte-enabled write
   always @(posedge clk) begin
      if (m_en && !m_we) begin
         m_rdata <= mem[m_addr];
      end else begin
         m_rdata <= $urandom;
      end
      if (m_en && m_we) begin
         for (int b = 0; b < 4; b++) begin
            if (m_be[b]) mem[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
         end
      end
   end

   // Reference model and scoreboard, evaluated mid-cycle while everything is stable
   always @(negedge clk) begin
      exp_t        e;
      bit          g0, g1, we, err;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      logic [11:0] idx;
      if (reset) begin
         check("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
         check("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
         check("rst_men", {31'd0, m_en}, 32'd0);
         sb.delete();
         wait_cnt = 0;
         seen0    = 1'b0;
         seen1    = 1'b0;
      end else begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rvalid", {30'd0, p1_rvalid, p0_rvalid}, e.port ? 32'd2 : 32'd1);
            check("rdata", e.port ? p1_rdata : p0_rdata, e.data);
            check("rdata_other", e.port ? p0_rdata : p1_rdata, 32'd0);
            check("err", {30'd0, p1_err, p0_err}, e.err ? (e.port ? 32'd2 : 32'd1) : 32'd0);
         end else begin
            check("rvalid_idle", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
            check("rdata_idle", p0_rdata | p1_rdata, 32'd0);
            check("err_idle", {30'd0, p1_err, p0_err}, 32'd0);
         end

         g1 = p1_req && ((wait_cnt == LIMIT) || !p0_req);
         g0 = p0_req && !g1;
         check("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, g1, g0});

         if (g0 || g1) begin
            we    = g1 ? p1_we    : p0_we;
            addr  = g1 ? p1_addr  : p0_addr;
            wdata = g1 ? p1_wdata : p0_wdata;
            be    = g1 ? p1_be    : p0_be;
            err   = model_err(addr, we, be);
            idx   = addr[13:2];
            if (err) begin
               check("m_bus_err", {m_en, m_we, m_be, 14'd0, m_addr} | m_wdata, 32'd0);
               e.data = 32'd0;
            end else begin
               check("m_en_we", {30'd0, m_en, m_we}, {30'd0, 1'b1, we});
               check("m_addr", {20'd0, m_addr}, {20'd0, idx});
               if (we) begin
                  check("m_be", {28'd0, m_be}, {28'd0, be});
                  check("m_wdata", m_wdata, wdata);
                  for (int b = 0; b < 4; b++) begin
                     if (be[b]) ref_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
                  end
                  e.data = 32'd0;
               end else begin
                  e.data = ref_mem[idx];
               end
            end
            e.port = g1;
            e.err  = err;
            sb.push_back(e);
         end else begin
            check("m_bus_idle", {m_en, m_we, m_be, 14'd0, m_addr} | m_wdata, 32'd0);
         end

         if (p1_req && !g1) wait_cnt = (wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT;
         else               wait_cnt = 0;
         seen0 = g0;
         seen1 = g1;
      end
   end

   // Advance one clock and present the head of each port's queue, retiring granted requests
   task automatic cycle();
      @(posedge clk);
      #1;
      if (seen0 && rq0.size() > 0) rq0.delete(0);
      if (seen1 && rq1.size() > 0) rq1.delete(0);
      seen0 = 1'b0;
      seen1 = 1'b0;
      if (rq0.size() > 0) begin
         p0_req = 1'b1; p0_we = rq0[0].we; p0_addr = rq0[0].addr;
         p0_wdata = rq0[0].wdata; p0_be = rq0[0].be;
      end else begin
         p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
      end
      if (rq1.size() > 0) begin
         p1_req = 1'b1; p1_we = rq1[0].we; p1_addr = rq1[0].addr;
         p1_wdata = rq1[0].wdata; p1_be = rq1[0].be;
      end else begin
         p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((rq0.size() > 0 || rq1.size() > 0 || sb.size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      check("drain_timeout", {31'd0, n < budget}, 32'd1);
   endtask

   function automatic req_t rnd_req();
      req_t        r;
      logic [3:0]  be_tab [8];
      be_tab = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h0};
      r.we    = $urandom_range(0, 1) == 1;
      r.addr  = $urandom_range(0, 32'h0000_4FFF);
      if ($urandom_range(0, 5) != 0) r.addr[1:0] = 2'b00;
      r.wdata = $urandom;
      r.be    = r.we ? be_tab[$urandom_range(0, 7)] : 4'hF;
      return r;
   endfunction

   initial begin
      int n;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = i * 32'h9E37_79B1;
      end
      mem[4] = 32'hDEAD_BEEF;
      for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

      // Load at 0x10 is pending during reset and must wait for reset release
      rq0.push_back('{1'b0, 32'h0000_0010, 32'd0, 4'hF});
      repeat (3) cycle();
      reset = 1'b0;
      drain(20);

      // Both ports loading continuously: port 1 wins every fifth cycle
      for (int i = 0; i < 12; i++) begin
         rq0.push_back('{1'b0, 32'(i * 4), 32'd0, 4'hF});
         rq1.push_back('{1'b0, 32'(32'h100 + i * 4), 32'd0, 4'hF});
      end
      drain(100);

      // Byte store then readback, followed by the error cases
      rq1.push_back('{1'b1, 32'h0000_0022, 32'h00AB_0000, 4'b0100});
      rq1.push_back('{1'b0, 32'h0000_0020, 32'd0, 4'hF});
      rq0.push_back('{1'b0, 32'h0000_4000, 32'd0, 4'hF});
      rq1.push_back('{1'b1, 32'h0000_0003, 32'h1234_5678, 4'hF});
      rq1.push_back('{1'b1, 32'h0000_0008, 32'h0000_0001, 4'h0});
      rq0.push_back('{1'b0, 32'hFFFF_FFFC, 32'd0, 4'hF});
      drain(50);

      // Mixed random traffic on both ports, back-to-back
      for (int i = 0; i < 60; i++) begin
         rq0.push_back(rnd_req());
         rq1.push_back(rnd_req());
      end
      drain(1000);

      // Reset in the cycle after a grant: response dropped, arbitration restarts clean
      rq0.push_back('{1'b0, 32'h0000_0010, 32'd0, 4'hF});
      rq1.push_back('{1'b0, 32'h0000_0014, 32'd0, 4'hF});
      n = 0;
      while (rq0.size() > 0 && n < 20) begin
         cycle();
         n++;
      end
      check("pre_reset_grant", {31'd0, n < 20}, 32'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      rq1.delete();
      for (int i = 0; i < 6; i++) begin
         rq0.push_back('{1'b0, 32'(32'h40 + i * 4), 32'd0, 4'hF});
         rq1.push_back('{1'b0, 32'(32'h80 + i * 4), 32'd0, 4'hF});
      end
      drain(100);
      repeat (2) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
